aes_link_server: RTL

// Parametrised FPGA-side AES responder between the inter-FPGA link (Fpga_Connection) and AES_Comp.

---
 rtl/aes_link_server_pkg.sv | 24 ++
 rtl/link_block_fifo.sv | 55 +++++
 rtl/aes_link_server.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_link_server_pkg.sv
// Shared constants and state type for the AES link responder.
//   - Command opcodes carried in frame bits [127:120].
//   - Status codes returned in bits [127:120] of a status frame.
//   - Responder FSM state encoding.
package aes_link_pkg;

    localparam logic [7:0] OP_LOAD_KEY = 8'h01;
    localparam logic [7:0] OP_ENC      = 8'h02;
    localparam logic [7:0] OP_DEC      = 8'h03;

    localparam logic [7:0] ST_KEY_OK   = 8'hA5;
    localparam logic [7:0] ST_BAD_OP   = 8'hEE;
    localparam logic [7:0] ST_TIMEOUT  = 8'hE7;

    // StKeyWait is the key-expansion handshake sub-phase of RUN.
    typedef enum logic [2:0] {
        StIdle, StCmd, StKeyRx, StRun, StKeyWait, StWait, StSend
    } link_state_e;

    function automatic logic [127:0] status_frame(input logic [7:0] code);
        return {code, 120'd0};
    endfunction

endpackage

// File: rtl/link_block_fifo.sv
// Inbound data-block FIFO with show-ahead output.
//   clk, rst       clock, asynchronous active-high reset
//   i_push, i_data write request and data (ignored when full unless popping)
//   i_pop          read request, o_data holds the head entry
//   i_flush        discard all entries
//   o_full/o_empty occupancy flags
module link_block_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/aes_link_server.sv
// FPGA-side AES responder between the inter-FPGA link and AES_Comp.
//   clk, rst                 clock, asynchronous active-high reset
//   rx_data/rx_valid         frames from the link receiver
//   tx_data/tx_send/tx_busy  frames to the link transmitter
//   aes_*                    AES_Comp key/data handshake, mode and active-low reset
//   trig                     scope trigger, high across each AES run
//   blk_count                data blocks returned since reset (wraps)
//   ovf                      sticky, a data frame was dropped on a full FIFO
module aes_link_server
    import aes_link_pkg::*;
#(
    parameter int unsigned  FIFO_DEPTH  = 4,
    parameter int unsigned  TIMEOUT_CYC = 1048576,
    parameter logic [127:0] DEFAULT_KEY = 128'h37d0d724d00a1248db0fead349f1c09b
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] rx_data,
    input  logic         rx_valid,
    output logic [127:0] tx_data,
    output logic         tx_send,
    input  logic         tx_busy,
    output logic [127:0] aes_kin,
    output logic [127:0] aes_din,
    output logic         aes_krdy,
    output logic         aes_drdy,
    output logic         aes_encdec,
    output logic         aes_rstn,
    input  logic [127:0] aes_dout,
    input  logic         aes_kvld,
    input  logic         aes_dvld,
    output logic         trig,
    output logic [31:0]  blk_count,
    output logic         ovf
);

    link_state_e  r_state;
    logic [127:0] r_tx_data, r_aes_kin, r_aes_din;
    logic         r_tx_send, r_krdy, r_drdy, r_encdec, r_aes_rstn, r_trig, r_ovf;
    logic         r_key_stale, r_exp_encdec, r_is_data;
    logic [8:0]   r_remaining;
    logic [31:0]  r_blk_count, r_tmo;

    logic         w_need_key, w_push, w_pop, w_full, w_empty, w_drop;
    logic         w_tmo_arm, w_tmo_hit;
    logic [127:0] w_fifo_data;
    logic [7:0]   w_opcode;

    assign w_opcode   = rx_data[127:120];
    // The core's expanded schedule is only valid for the key and direction last expanded.
    assign w_need_key = r_key_stale || (r_encdec != r_exp_encdec);
    assign w_push     = rx_valid && (r_state inside {StRun, StKeyWait, StWait, StSend});
    assign w_pop      = (r_state == StRun) && !w_need_key && !w_empty;
    assign w_drop     = w_push && w_full && !w_pop;

    // Counter only runs while waiting on the host; any other state holds it at zero,
    // which also clears it on every state change.
    assign w_tmo_arm  = (r_state == StKeyRx) ||
                        ((r_state == StRun) && w_empty && !w_need_key);
    assign w_tmo_hit  = w_tmo_arm && !rx_valid && (r_tmo == 32'(TIMEOUT_CYC - 1));

    link_block_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (128)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (rx_data),
        .i_pop   (w_pop),
        .i_flush (w_tmo_hit),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (rx_valid || !w_tmo_arm) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_tx_data    <= '0;
            r_tx_send    <= 1'b0;
            r_aes_kin    <= DEFAULT_KEY;
            r_aes_din    <= '0;
            r_krdy       <= 1'b0;
            r_drdy       <= 1'b0;
            r_encdec     <= 1'b0;
            r_exp_encdec <= 1'b0;
            r_aes_rstn   <= 1'b0;
            r_trig       <= 1'b0;
            r_blk_count  <= '0;
            r_ovf        <= 1'b0;
            r_key_stale  <= 1'b1;
            r_is_data    <= 1'b0;
            r_remaining  <= '0;
        end else begin
            r_tx_send <= 1'b0;
            r_krdy    <= 1'b0;
            r_drdy    <= 1'b0;
            if (w_drop) r_ovf <= 1'b1;

            unique case (r_state)
                StIdle: begin
                    r_aes_rstn <= 1'b1;
                    r_state    <= StCmd;
                end
                StCmd: begin
                    if (rx_valid) begin
                        if (w_opcode == OP_LOAD_KEY) begin
                            r_state <= StKeyRx;
                        end else if (w_opcode == OP_ENC || w_opcode == OP_DEC) begin
                            r_encdec    <= (w_opcode == OP_DEC);
                            r_remaining <= {1'b0, rx_data[7:0]} + 9'd1;
                            r_state     <= StRun;
                        end else begin
                            r_tx_data <= status_frame(ST_BAD_OP);
                            r_is_data <= 1'b0;
                            r_state   <= StSend;
                        end
                    end
                end
                StKeyRx: begin
                    if (rx_valid) begin
                        r_aes_kin   <= rx_data;
                        r_key_stale <= 1'b1;
                        r_tx_data   <= status_frame(ST_KEY_OK);
                        r_is_data   <= 1'b0;
                        r_state     <= StSend;
                    end else if (w_tmo_hit) begin
                        r_tx_data <= status_frame(ST_TIMEOUT);
                        r_is_data <= 1'b0;
                        r_state   <= StSend;
                    end
                end
                StRun: begin
                    if (w_need_key) begin
                        r_krdy  <= 1'b1;
                        r_state <= StKeyWait;
                    end else if (!w_empty) begin
                        r_aes_din <= w_fifo_data;
                        r_drdy    <= 1'b1;
                        r_trig    <= 1'b1;
                        r_state   <= StWait;
                    end else if (w_tmo_hit) begin
                        r_tx_data <= status_frame(ST_TIMEOUT);
                        r_is_data <= 1'b0;
                        r_state   <= StSend;
                    end
                end
                StKeyWait: begin
                    if (aes_kvld) begin
                        r_key_stale  <= 1'b0;
                        r_exp_encdec <= r_encdec;
                        r_state      <= StRun;
                    end
                end
                StWait: begin
                    if (aes_dvld) begin
                        r_tx_data <= aes_dout;
                        r_trig    <= 1'b0;
                        r_is_data <= 1'b1;
                        r_state   <= StSend;
                    end
                end
                StSend: begin
                    if (!tx_busy) begin
                        r_tx_send <= 1'b1;
                        if (r_is_data && r_remaining != 9'd1) begin
                            r_blk_count <= r_blk_count + 32'd1;
                            r_remaining <= r_remaining - 9'd1;
                            r_state     <= StRun;
                        end else begin
                            if (r_is_data) r_blk_count <= r_blk_count + 32'd1;
                            r_aes_rstn <= 1'b0;
                            r_state    <= StIdle;
                        end
                    end
                end
                default: begin
                    r_aes_rstn <= 1'b0;
                    r_state    <= StIdle;
                end
            endcase
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_send    = r_tx_send;
    assign aes_kin    = r_aes_kin;
    assign aes_din    = r_aes_din;
    assign aes_krdy   = r_krdy;
    assign aes_drdy   = r_drdy;
    assign aes_encdec = r_encdec;
    assign aes_rstn   = r_aes_rstn;
    assign trig       = r_trig;
    assign blk_count  = r_blk_count;
    assign ovf        = r_ovf;

endmodule
